// File: rtl/rs_multi_cdb.sv
// rs_multi_cdb -- reservation station for the ALU path.
//
// Holds up to RS_SIZE issued ALU operations until both source operands are
// known. Then it sends the oldest ready one to the ALU.
// Operands are captured from any of NUM_CDB broadcast channels. Capture also
// works in the cycle the operation is issued.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global enable; low freezes every register
//   rollback            synchronous flush (acts like rst)
//   issue_valid ...     issue request: op/imm/pc/dest tag plus two operands,
//                       each given as a value (vX_in) or a pending tag
//                       (qX_in with qX_busy_in=1)
//   cdb_valid/tag/data  NUM_CDB broadcast channels, channel c in slice c
//   alu_ready           ALU accepts a dispatch at this edge
//   calc_valid, *_out   registered dispatch strobe and payload
//   rs_full, rs_count   occupancy (registered count)
//
// Handshake: a dispatch takes place at an edge where rdy=1, rst=0,
// rollback=0, alu_ready=1 and at least one entry is ready. At that edge the
// entry is freed and calc_valid/payload are loaded. When rdy=1 and no
// dispatch takes place, calc_valid drops to 0 and the payload holds.
module rs_multi_cdb #(
  parameter int RS_SIZE = 16,
  parameter int ROB_W   = 4,
  parameter int NUM_CDB = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     rollback,
  input  logic                     issue_valid,
  input  logic                     is_load_store,
  input  logic [5:0]               op_in,
  input  logic [31:0]              imm_in,
  input  logic [31:0]              pc_in,
  input  logic [ROB_W-1:0]         entry_in,
  input  logic [31:0]              vj_in,
  input  logic [31:0]              vk_in,
  input  logic [ROB_W-1:0]         qj_in,
  input  logic [ROB_W-1:0]         qk_in,
  input  logic                     qj_busy_in,
  input  logic                     qk_busy_in,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*ROB_W-1:0] cdb_tag,
  input  logic [NUM_CDB*32-1:0]    cdb_data,
  input  logic                     alu_ready,
  output logic                     calc_valid,
  output logic [5:0]               op_out,
  output logic [31:0]              vj_out,
  output logic [31:0]              vk_out,
  output logic [31:0]              imm_out,
  output logic [31:0]              pc_out,
  output logic [ROB_W-1:0]         entry_out,
  output logic                     rs_full,
  output logic [$clog2(RS_SIZE):0] rs_count
);
  localparam int IDX_W = $clog2(RS_SIZE);
  localparam int CNT_W = IDX_W + 1;

  logic [RS_SIZE-1:0] r_valid, r_qj_busy, r_qk_busy;
  logic [ROB_W-1:0]   r_qj [RS_SIZE];
  logic [ROB_W-1:0]   r_qk [RS_SIZE];
  logic [ROB_W-1:0]   r_entry [RS_SIZE];
  logic [31:0]        r_vj [RS_SIZE];
  logic [31:0]        r_vk [RS_SIZE];
  logic [31:0]        r_imm [RS_SIZE];
  logic [31:0]        r_pc [RS_SIZE];
  logic [5:0]         r_op [RS_SIZE];
  // Age matrix: r_older[i][j] = 1 means entry i was issued before entry j.
  logic [RS_SIZE-1:0] r_older [RS_SIZE];

  logic [RS_SIZE-1:0] w_ready, w_blocked, w_sel_oh;
  logic [RS_SIZE-1:0] w_j_hit, w_k_hit;
  logic [31:0]        w_j_data [RS_SIZE];
  logic [31:0]        w_k_data [RS_SIZE];
  logic               w_ij_hit, w_ik_hit;
  logic [31:0]        w_ij_data, w_ik_data;
  logic [IDX_W-1:0]   w_free_idx, w_sel_idx;
  logic               w_issue, w_dispatch;

  assign rs_full    = (rs_count == CNT_W'(RS_SIZE));
  assign w_issue    = issue_valid && !is_load_store && !rs_full;
  assign w_ready    = r_valid & ~r_qj_busy & ~r_qk_busy;
  assign w_dispatch = (|w_ready) && alu_ready;

  // Wakeup: the channels are scanned from high to low, so the lowest
  // matching channel is written last and supplies the data.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      w_j_hit[i]  = 1'b0;
      w_k_hit[i]  = 1'b0;
      w_j_data[i] = '0;
      w_k_data[i] = '0;
      for (int c = NUM_CDB - 1; c >= 0; c--) begin
        if (cdb_valid[c] && cdb_tag[c*ROB_W +: ROB_W] == r_qj[i]) begin
          w_j_hit[i]  = 1'b1;
          w_j_data[i] = cdb_data[c*32 +: 32];
        end
        if (cdb_valid[c] && cdb_tag[c*ROB_W +: ROB_W] == r_qk[i]) begin
          w_k_hit[i]  = 1'b1;
          w_k_data[i] = cdb_data[c*32 +: 32];
        end
      end
    end
  end

  // Same lookup for the operands of the issuing instruction (issue bypass).
  always_comb begin
    w_ij_hit  = 1'b0;
    w_ik_hit  = 1'b0;
    w_ij_data = '0;
    w_ik_data = '0;
    for (int c = NUM_CDB - 1; c >= 0; c--) begin
      if (cdb_valid[c] && cdb_tag[c*ROB_W +: ROB_W] == qj_in) begin
        w_ij_hit  = 1'b1;
        w_ij_data = cdb_data[c*32 +: 32];
      end
      if (cdb_valid[c] && cdb_tag[c*ROB_W +: ROB_W] == qk_in) begin
        w_ik_hit  = 1'b1;
        w_ik_data = cdb_data[c*32 +: 32];
      end
    end
  end

  // An entry is blocked when some older entry is also ready.
  always_comb begin
    w_blocked = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      for (int j = 0; j < RS_SIZE; j++) begin
        if (j != i && w_ready[j] && r_older[j][i]) w_blocked[i] = 1'b1;
      end
    end
  end
  assign w_sel_oh = w_ready & ~w_blocked;

  always_comb begin
    w_sel_idx  = '0;
    w_free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (w_sel_oh[i]) w_sel_idx = IDX_W'(i);
      if (!r_valid[i]) w_free_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || rollback) begin
      r_valid    <= '0;
      r_qj_busy  <= '0;
      r_qk_busy  <= '0;
      calc_valid <= 1'b0;
      op_out     <= '0;
      vj_out     <= '0;
      vk_out     <= '0;
      imm_out    <= '0;
      pc_out     <= '0;
      entry_out  <= '0;
      rs_count   <= '0;
    end else if (rdy) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (r_valid[i] && r_qj_busy[i] && w_j_hit[i]) begin
          r_qj_busy[i] <= 1'b0;
          r_vj[i]      <= w_j_data[i];
        end
        if (r_valid[i] && r_qk_busy[i] && w_k_hit[i]) begin
          r_qk_busy[i] <= 1'b0;
          r_vk[i]      <= w_k_data[i];
        end
      end

      calc_valid <= w_dispatch;
      if (w_dispatch) begin
        r_valid[w_sel_idx] <= 1'b0;
        op_out    <= r_op[w_sel_idx];
        vj_out    <= r_vj[w_sel_idx];
        vk_out    <= r_vk[w_sel_idx];
        imm_out   <= r_imm[w_sel_idx];
        pc_out    <= r_pc[w_sel_idx];
        entry_out <= r_entry[w_sel_idx];
      end

      // The free slot is EMPTY in the registered state, so it never
      // collides with the wakeup or dispatch updates above.
      if (w_issue) begin
        r_valid[w_free_idx]   <= 1'b1;
        r_op[w_free_idx]      <= op_in;
        r_imm[w_free_idx]     <= imm_in;
        r_pc[w_free_idx]      <= pc_in;
        r_entry[w_free_idx]   <= entry_in;
        r_qj[w_free_idx]      <= qj_in;
        r_qk[w_free_idx]      <= qk_in;
        r_qj_busy[w_free_idx] <= qj_busy_in && !w_ij_hit;
        r_qk_busy[w_free_idx] <= qk_busy_in && !w_ik_hit;
        r_vj[w_free_idx]      <= (qj_busy_in && w_ij_hit) ? w_ij_data : vj_in;
        r_vk[w_free_idx]      <= (qk_busy_in && w_ik_hit) ? w_ik_data : vk_in;
        // The new entry is younger than every entry currently held.
        r_older[w_free_idx]   <= '0;
        for (int j = 0; j < RS_SIZE; j++) begin
          if (j != int'(w_free_idx)) r_older[j][w_free_idx] <= r_valid[j];
        end
      end

      if (w_issue && !w_dispatch) rs_count <= rs_count + CNT_W'(1);
      else if (!w_issue && w_dispatch) rs_count <= rs_count - CNT_W'(1);
    end
  end
endmodule

// File: doc/rs_multi_cdb.md
# rs_multi_cdb

Parametrised reservation station for the out-of-order core's ALU path. It replaces the fixed 32-entry station with configurable depth, ROB-tag width and broadcast-channel count. Operands are captured from any broadcast channel, including the issue cycle itself, and the oldest ready entry is dispatched to the ALU under a ready handshake. It sits between the issue stage (decoder + regfile lookup) and the ALU; all result producers (ALU, LSB, ROB commit) drive its broadcast channels.

## Interface
- RS_SIZE, 16, number of station entries (power of two, 2..64)
- ROB_W, 4, ROB tag width in bits
- NUM_CDB, 3, number of broadcast channels (ALU, LSB, ROB commit by default)
- clk  in  1  clock; one clock domain only
- rst  in  1  reset, synchronous and active-high
- rdy  in  1  global enable; low freezes all state and outputs
- rollback  in  1  misprediction flush, synchronous
- issue_valid  in  1  issue request this cycle
- is_load_store  in  1  request belongs to LSB; station ignores it
- op_in  in  6  ALU opcode
- imm_in, pc_in  in  32 each  immediate, instruction PC
- entry_in  in  ROB_W  destination ROB tag
- vj_in, vk_in  in  32 each  operand values (valid when matching busy bit is 0)
- qj_in, qk_in  in  ROB_W each  producer tags
- qj_busy_in, qk_busy_in  in  1 each  operand still pending
- cdb_valid  in  NUM_CDB  per-channel broadcast strobe
- cdb_tag  in  NUM_CDB*ROB_W  channel c at bits [c*ROB_W +: ROB_W]
- cdb_data  in  NUM_CDB*32  channel c at bits [c*32 +: 32]
- alu_ready  in  1  ALU accepts a dispatch at this edge
- calc_valid  out  1  dispatch strobe (registered)
- op_out, vj_out, vk_out, imm_out, pc_out, entry_out  out  6/32/32/32/32/ROB_W  dispatched payload (registered)
- rs_full  out  1  count == RS_SIZE
- rs_count  out  clog2(RS_SIZE)+1  occupied entries (registered)

## Operation
- Entry state: EMPTY or VALID. An entry is ready when VALID and both busy bits are 0 in the registered state.
- Issue: accepted when issue_valid && !is_load_store && !rs_full. Written into the lowest-index EMPTY slot. Issue while full is dropped with no state change.
- Issue bypass: if qj_busy_in is set and some channel broadcasts qj_in in the same cycle, the entry is written with busy=0 and that channel's data. The same rule applies independently to k.
- Wakeup: every cycle, each VALID entry compares both pending tags against all channels. j and k are resolved independently, so one broadcast clears both when the tags match. If several channels match, the lowest channel index supplies the data.
- Select: among ready entries, the one issued earliest wins (true age order, via age matrix or per-entry sequence stamp). The selected entry goes EMPTY at the dispatch edge.
- Dispatch: happens when a ready entry exists and alu_ready=1. It sets calc_valid=1 and the payload. Otherwise calc_valid=0 and the payload holds its last value.
- rs_count: +1 on accepted issue, −1 on dispatch, unchanged when both occur.
- rs_full uses the registered count. A slot freed at an edge is usable from the next cycle.

## Timing
- Reset or rollback, at a clk edge: all entries EMPTY, busy bits 0, calc_valid=0, all payload outputs 0, entry_out=0, rs_count=0, rs_full=0.
- rst and rollback act regardless of rdy. rollback in the same cycle as issue or dispatch discards both.
- rdy=0: no issue, wakeup, dispatch or count change. All outputs hold, including calc_valid; the ALU is also frozen by rdy.
- Ready-at-issue latency: issue at edge N, calc_valid at edge N+1 (1 cycle).
- Wakeup latency: broadcast at edge N, dispatch at edge N+1.
- Bypass at issue: issue and matching broadcast at edge N, dispatch at edge N+1.
- alu_ready=0: the ready entry stays VALID and is re-selected each cycle. Age order is preserved across stalls.

## Test plan
- Issue three independent ops (entries 1,2,3) on consecutive cycles, alu_ready=1 -> calc_valid on the three following edges, entry_out 1,2,3, rs_count peaks at 1.
- Issue op with qj=qk=5 both busy, then broadcast tag 5 data 0x1234 on channel 1 -> next edge dispatch with vj_out=vk_out=0x1234.
- Hold alu_ready=0, issue entries 7 then 2 (both ready), raise alu_ready -> entry_out=7 first, then 2.
- Fill RS_SIZE entries with busy operands -> rs_full=1. Extra issue dropped (rs_count stays RS_SIZE). One wakeup and dispatch -> rs_full=0 the edge after.
- Issue with qj busy tag 3 while channel 0 and channel 2 both broadcast tag 3 (0xA, 0xB) -> entry captured ready with vj=0xA, dispatched next edge.
- With 4 entries valid, pulse rollback together with an issue -> rs_count=0, calc_valid=0 next edge. With rdy=0 during a pending dispatch -> calc_valid and payload unchanged until rdy=1.
